// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with valid/ready handshakes.
// S1 registers the operand/opcode bundle, S2 registers the result and flags.
// Optional feature macro: ALU_PIPE_STICKY_OVF_EN adds a sticky overflow flag
// (OvfSticky, cleared by OvfClr). Without it OvfSticky is tied low.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    input  logic             OvfClr,
    output logic             OvfSticky
);

    localparam int MSB = WIDTH - 1;

    logic             s1Valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    logic             s2Valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    logic             transfer;
    logic             accept;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             ovf_d;

    // S1 moves into S2 whenever S2 is empty or is being drained this cycle;
    // a fresh bundle may enter S1 when it is empty or emptying.
    assign transfer = s1Valid_q && (!s2Valid_q || out_ready);
    assign in_ready = !s1Valid_q || transfer;
    assign accept   = in_valid && in_ready;

    // Compute the result and flags from the registered S1 bundle only.
    always_comb begin
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
        logic             addOvf;
        logic             subOvf;
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        addOvf   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
        subOvf   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
        result_d = '0;
        ovf_d    = 1'b0;
        case (op_q)
            3'b000: result_d = a_q & b_q;
            3'b001: result_d = a_q | b_q;
            3'b010: begin
                result_d = sum;
                ovf_d    = addOvf;
            end
            3'b011: result_d = ~(a_q & b_q);
            3'b100: result_d = ~(a_q | b_q);
            3'b101: result_d = a_q ^ b_q;
            3'b110: begin
                result_d = diff;
                ovf_d    = subOvf;
            end
            3'b111: begin
                result_d = {{MSB{1'b0}}, diff[MSB] ^ subOvf};
                ovf_d    = subOvf;
            end
            default: begin
                result_d = '0;
                ovf_d    = 1'b0;
            end
        endcase
        zero_d = (result_d == '0);
    end

    // Stage 1: capture an accepted bundle, otherwise empty out on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
        end else if (accept) begin
            s1Valid_q <= 1'b1;
            a_q       <= A;
            b_q       <= B;
            op_q      <= Operation;
        end else if (transfer) begin
            s1Valid_q <= 1'b0;
        end
    end

    // Stage 2: load the computed result on transfer, clear after handshake,
    // and otherwise hold so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (transfer) begin
            s2Valid_q <= 1'b1;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
        end else if (s2Valid_q && out_ready) begin
            s2Valid_q <= 1'b0;
        end
    end

    assign out_valid = s2Valid_q;
    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;

`ifdef ALU_PIPE_STICKY_OVF_EN
    logic sticky_q;

    // Sticky overflow: set when an overflowing result enters S2; a clear
    // on the same edge loses to the set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (transfer && ovf_d) begin
            sticky_q <= 1'b1;
        end else if (OvfClr) begin
            sticky_q <= 1'b0;
        end
    end

    assign OvfSticky = sticky_q;
`else
    logic unusedOvfClr;
    assign unusedOvfClr = OvfClr;
    assign OvfSticky    = 1'b0;
`endif

endmodule
